// File: rtl/lsu_rv32i.sv
// RV32I load/store unit: legality check, byte-lane steering, ready handshake with
// timeout, and sign/zero extension of load data. Stalls the core while busy.
module lsu_rv32i #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             OpValid,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] Addr,
  input  logic [WIDTH-1:0] StoreData,
  output logic             Stall,
  output logic             Done,
  output logic [WIDTH-1:0] LoadData,
  output logic             Fault,
  output logic [1:0]       FaultCause,
  output logic             DMemReq,
  output logic             DMemWe,
  output logic [WIDTH-1:0] DMemAddr,
  output logic [WIDTH-1:0] DMemWData,
  output logic [3:0]       DMemBe,
  input  logic             DMemReady,
  input  logic [WIDTH-1:0] DMemRData
);

  localparam int unsigned CW = 8;
  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_MIS  = 2'b01;
  localparam logic [1:0] CAUSE_ILL  = 2'b10;
  localparam logic [1:0] CAUSE_TMO  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx, cnt_inc;
  logic [2:0]      ltype, ltype_nx;
  logic [1:0]      off, off_nx;
  logic            req_nx, we_nx, done_nx, fault_nx;
  logic [1:0]      cause_nx;
  logic [3:0]      be_nx;
  logic [WIDTH-1:0] addr_nx, wdata_nx, ldata_nx;

  logic             accept, bad_op, misaligned;
  logic [3:0]       be_acc;
  logic [WIDTH-1:0] wdata_acc, shifted, load_ext;

  assign accept  = OpValid && (MemRead || MemWrite);
  assign cnt_inc = cnt + CW'(1);
  assign Stall   = ((state == S_IDLE) && accept) || (state == S_REQ);

  // Illegal combinations and encodings, then natural-alignment check by size
  always_comb begin
    bad_op = 1'b0;
    if (MemRead && MemWrite) begin
      bad_op = 1'b1;
    end else if (MemRead) begin
      bad_op = (Funct3 == 3'b011) || (Funct3 == 3'b110) || (Funct3 == 3'b111);
    end else if (MemWrite) begin
      bad_op = Funct3[2] || (Funct3[1:0] == 2'b11);
    end
    misaligned = ((Funct3[1:0] == 2'b01) && Addr[0]) ||
                 ((Funct3[1:0] == 2'b10) && (Addr[1:0] != 2'b00));
  end

  // Byte enables by size and offset; store data replicated across lanes
  always_comb begin
    be_acc    = 4'b1111;
    wdata_acc = StoreData;
    case (Funct3[1:0])
      2'b00: begin
        be_acc    = 4'b0001 << Addr[1:0];
        wdata_acc = {(WIDTH/8){StoreData[7:0]}};
      end
      2'b01: begin
        be_acc    = 4'b0011 << Addr[1:0];
        wdata_acc = {(WIDTH/16){StoreData[15:0]}};
      end
      default: ;
    endcase
    if (!MemWrite) wdata_acc = '0;
  end

  // Load extraction from the registered byte offset and load type
  always_comb begin
    shifted = DMemRData >> {off, 3'b000};
    case (ltype)
      3'b000:  load_ext = {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {{(WIDTH-8){1'b0}}, shifted[7:0]};
      3'b101:  load_ext = {{(WIDTH-16){1'b0}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ltype_nx = ltype;
    off_nx   = off;
    req_nx   = 1'b0;
    we_nx    = DMemWe;
    be_nx    = DMemBe;
    addr_nx  = DMemAddr;
    wdata_nx = DMemWData;
    ldata_nx = LoadData;
    done_nx  = 1'b0;
    fault_nx = 1'b0;
    cause_nx = CAUSE_NONE;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (bad_op || misaligned) begin
            state_nx = S_DONE;
            done_nx  = 1'b1;
            fault_nx = 1'b1;
            cause_nx = bad_op ? CAUSE_ILL : CAUSE_MIS;
          end else begin
            state_nx = S_REQ;
            req_nx   = 1'b1;
            cnt_nx   = '0;
            we_nx    = MemWrite;
            be_nx    = be_acc;
            addr_nx  = {Addr[WIDTH-1:2], 2'b00};
            wdata_nx = wdata_acc;
            ltype_nx = Funct3;
            off_nx   = Addr[1:0];
          end
        end
      end
      S_REQ: begin
        cnt_nx = cnt_inc;
        req_nx = 1'b1;
        if (DMemReady) begin
          state_nx = S_DONE;
          req_nx   = 1'b0;
          done_nx  = 1'b1;
          ldata_nx = DMemWe ? '0 : load_ext;
        end else if (cnt_inc == CW'(TIMEOUT)) begin
          state_nx = S_DONE;
          req_nx   = 1'b0;
          done_nx  = 1'b1;
          fault_nx = 1'b1;
          cause_nx = CAUSE_TMO;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      ltype      <= '0;
      off        <= '0;
      DMemReq    <= 1'b0;
      DMemWe     <= 1'b0;
      DMemBe     <= '0;
      DMemAddr   <= '0;
      DMemWData  <= '0;
      LoadData   <= '0;
      Done       <= 1'b0;
      Fault      <= 1'b0;
      FaultCause <= CAUSE_NONE;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      ltype      <= ltype_nx;
      off        <= off_nx;
      DMemReq    <= req_nx;
      DMemWe     <= we_nx;
      DMemBe     <= be_nx;
      DMemAddr   <= addr_nx;
      DMemWData  <= wdata_nx;
      LoadData   <= ldata_nx;
      Done       <= done_nx;
      Fault      <= fault_nx;
      FaultCause <= cause_nx;
    end
  end

endmodule

// File: tb/tb_lsu_rv32i.sv
// Directed plus randomized checks of lsu_rv32i against a byte-level reference model.
module tb_lsu_rv32i;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        OpValid, MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] Addr, StoreData;
  logic        Stall, Done, Fault;
  logic [31:0] LoadData;
  logic [1:0]  FaultCause;
  logic        DMemReq, DMemWe, DMemReady;
  logic [31:0] DMemAddr, DMemWData, DMemRData;
  logic [3:0]  DMemBe;

  int checks = 0;
  int errors = 0;

  lsu_rv32i #(.WIDTH(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .OpValid(OpValid), .MemRead(MemRead), .MemWrite(MemWrite),
    .Funct3(Funct3), .Addr(Addr), .StoreData(StoreData), .Stall(Stall), .Done(Done),
    .LoadData(LoadData), .Fault(Fault), .FaultCause(FaultCause), .DMemReq(DMemReq),
    .DMemWe(DMemWe), .DMemAddr(DMemAddr), .DMemWData(DMemWData), .DMemBe(DMemBe),
    .DMemReady(DMemReady), .DMemRData(DMemRData)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Value of the selected bytes, sign-extended from the top byte when signed
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] o,
                                           input logic [31:0] rdata);
    int nbytes = 1 << f3[1:0];
    longint v = 0;
    for (int i = 0; i < nbytes; i++)
      v += longint'((rdata >> (8 * (int'(o) + i))) & 32'hFF) << (8 * i);
    if (!f3[2] && nbytes < 4 && v >= (longint'(1) << (8 * nbytes - 1)))
      v -= longint'(1) << (8 * nbytes);
    return 32'(v);
  endfunction

  task automatic do_op(input string tag, input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [31:0] rdata, input int ready_on);
    int nbytes = 1 << f3[1:0];
    bit illegal, misal, fault_exp, tmo;
    logic [1:0]  cause_exp;
    logic [3:0]  be_exp;
    logic [31:0] wdata_exp, ldata_exp;
    int stall_cnt, req_cycles, req_exp, stall_exp;
    bit seen;

    illegal = (rd && wr) || (rd && (f3 == 3'd3 || f3 >= 3'd6)) || (!rd && wr && f3 >= 3'd3);
    misal   = !illegal && ((addr % nbytes) != 0);
    tmo     = !illegal && !misal && (ready_on == 0 || ready_on > int'(TMO));
    fault_exp = illegal || misal || tmo;
    cause_exp = illegal ? 2'b10 : misal ? 2'b01 : tmo ? 2'b11 : 2'b00;
    be_exp    = 4'(((1 << nbytes) - 1) << addr[1:0]);
    wdata_exp = '0;
    if (wr) for (int i = 0; i < 4; i++) wdata_exp[8*i +: 8] = sdata[8*(i % nbytes) +: 8];
    ldata_exp = wr ? 32'h0 : ref_load(f3, addr[1:0], rdata);
    req_exp   = (illegal || misal) ? 0 : tmo ? int'(TMO) : ready_on;
    stall_exp = 1 + req_exp;

    @(negedge clk);
    OpValid = 1'b1; MemRead = rd; MemWrite = wr; Funct3 = f3; Addr = addr; StoreData = sdata;
    DMemReady = 1'b0;
    #1;
    chk({tag, ".stall_accept"}, 32'(Stall), 32'd1);
    stall_cnt = 1; req_cycles = 0; seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (Done) begin
        seen = 1;
        chk({tag, ".fault"}, 32'(Fault), 32'(fault_exp));
        chk({tag, ".cause"}, 32'(FaultCause), 32'(cause_exp));
        chk({tag, ".stall_done"}, 32'(Stall), 32'd0);
        chk({tag, ".req_done"}, 32'(DMemReq), 32'd0);
        chk({tag, ".req_cycles"}, 32'(req_cycles), 32'(req_exp));
        chk({tag, ".stall_cycles"}, 32'(stall_cnt), 32'(stall_exp));
        if (!fault_exp) chk({tag, ".ldata"}, LoadData, ldata_exp);
        OpValid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; DMemReady = 1'b0;
      end else begin
        if (Stall) stall_cnt++;
        if (DMemReq) begin
          req_cycles++;
          chk({tag, ".addr"}, DMemAddr, {addr[31:2], 2'b00});
          chk({tag, ".be"}, 32'(DMemBe), 32'(be_exp));
          chk({tag, ".we"}, 32'(DMemWe), 32'(wr));
          chk({tag, ".wdata"}, DMemWData, wdata_exp);
        end
        DMemReady = DMemReq && (req_cycles == ready_on);
        DMemRData = DMemReady ? rdata : $urandom;
      end
    end
    if (!seen) chk({tag, ".done_never_seen"}, 32'd0, 32'd1);
    @(negedge clk);
    chk({tag, ".done_strobe_len"}, 32'(Done), 32'd0);
    chk({tag, ".fault_clear"}, {30'd0, Fault, 1'b0} | 32'(FaultCause), 32'd0);
    if (!fault_exp) chk({tag, ".ldata_hold"}, LoadData, ldata_exp);
  endtask

  initial begin
    rst_n = 1'b0; OpValid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = '0;
    Addr = '0; StoreData = '0; DMemReady = 1'b0; DMemRData = '0;
    repeat (2) @(negedge clk);
    chk("rst.req", 32'(DMemReq), 32'd0);
    chk("rst.done", {29'd0, Done, Fault, Stall}, 32'd0);
    chk("rst.ldata", LoadData, 32'd0);
    chk("rst.addr", DMemAddr | DMemWData | 32'(DMemBe) | 32'(DMemWe), 32'd0);
    rst_n = 1'b1;

    do_op("lw",  1, 0, 3'b010, 32'h0000_1008, 32'h0, 32'hDEAD_BEEF, 1);
    do_op("lb",  1, 0, 3'b000, 32'h0000_1003, 32'h0, 32'h8012_3456, 1);
    do_op("lbu", 1, 0, 3'b100, 32'h0000_1003, 32'h0, 32'h8012_3456, 2);
    do_op("lhu", 1, 0, 3'b101, 32'h0000_1002, 32'h0, 32'h9ABC_0000, 1);
    do_op("lh",  1, 0, 3'b001, 32'h0000_1002, 32'h0, 32'h9ABC_0000, 3);
    do_op("sb",  0, 1, 3'b000, 32'h0000_2001, 32'h1234_56A5, 32'h0, 1);
    do_op("sh",  0, 1, 3'b001, 32'h0000_2002, 32'h1234_56A5, 32'h0, 1);
    do_op("sw",  0, 1, 3'b010, 32'h0000_2004, 32'h1234_56A5, 32'h0, 2);
    do_op("mis_lw", 1, 0, 3'b010, 32'h0000_1006, 32'h0, 32'h0, 1);
    do_op("mis_sh", 0, 1, 3'b001, 32'h0000_1003, 32'h0, 32'h0, 1);
    do_op("ill_f3", 1, 0, 3'b011, 32'h0000_1000, 32'h0, 32'h0, 1);
    do_op("ill_sf3", 0, 1, 3'b100, 32'h0000_1000, 32'h0, 32'h0, 1);
    do_op("ill_rw", 1, 1, 3'b010, 32'h0000_1000, 32'h0, 32'h0, 1);
    do_op("tmo",   1, 0, 3'b010, 32'h0000_3000, 32'h0, 32'h1111_2222, 0);
    do_op("tmo_edge", 1, 0, 3'b010, 32'h0000_3000, 32'h0, 32'h1357_9BDF, int'(TMO));

    for (int n = 0; n < 60; n++) begin
      bit rd, wr;
      int kind = $urandom_range(0, 9);
      rd = (kind < 5) || (kind == 9);
      wr = (kind >= 5);
      do_op("rand", rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
            $urandom_range(0, 5));
    end

    // Asynchronous reset in the middle of a request
    @(negedge clk);
    OpValid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; Addr = 32'h0000_4000;
    DMemReady = 1'b0;
    @(negedge clk);
    chk("midrst.req_before", 32'(DMemReq), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.req", 32'(DMemReq), 32'd0);
    chk("midrst.outs", {29'd0, Done, Fault, 1'b0} | 32'(FaultCause) | 32'(DMemBe), 32'd0);
    chk("midrst.addr", DMemAddr | LoadData, 32'd0);
    OpValid = 1'b0; MemRead = 1'b0;
    #1;
    chk("midrst.stall", 32'(Stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("post_rst", 1, 0, 3'b001, 32'h0000_5002, 32'h0, 32'h7FFF_1234, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
